seq_bin2bcd: RTL and testbench



---
 rtl/seq_bin2bcd_if.sv | 24 ++
 rtl/seq_bin2bcd.sv | 123 ++++++++++++
 tb/tb_seq_bin2bcd.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/seq_bin2bcd_if.sv
// Start/done handshake and result bundle for the sequential
// binary-to-BCD converter.
interface seq_bin2bcd_if #(
    parameter int BIN_W  = 18,
    parameter int DIGITS = 6
);
    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  overflow;
    logic                  neg;

    modport master (
        output start, bin_in,
        input  busy, done, bcd_out, overflow, neg
    );

    modport slave (
        input  start, bin_in,
        output busy, done, bcd_out, overflow, neg
    );
endinterface

// File: rtl/seq_bin2bcd.sv
// Iterative double-dabble binary-to-BCD converter, one bit per clock.
// Define SEQ_BIN2BCD_SIGNED_EN for two's-complement input with a sign flag.
module seq_bin2bcd #(
    parameter int BIN_W  = 18,
    parameter int DIGITS = 6
) (
    input logic         clk,
    input logic         rst_n,
    seq_bin2bcd_if.slave bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [BIN_W-1:0] operand;
    logic [BCD_W-1:0] scratch;
    logic [BCD_W-1:0] adj;
    logic [BCD_W-1:0] scratch_nxt;
    logic [CNT_W-1:0] cnt;
    logic             sticky;
    logic             carry;
    logic             busy;
    logic             done;
    logic [BCD_W-1:0] bcd;
    logic             ovf;
    logic [BIN_W-1:0] mag;

    // Every digit is corrected from the current value before the shift
    always_comb begin
        adj = scratch;
        for (int k = 0; k < DIGITS; k++) begin
            if (scratch[4*k +: 4] >= 4'd5)
                adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
        end
    end

    assign carry       = adj[BCD_W-1];
    assign scratch_nxt = {adj[BCD_W-2:0], operand[BIN_W-1]};

`ifdef SEQ_BIN2BCD_SIGNED_EN
    logic sign;
    logic sign_q;
    logic neg_q;

    assign sign = bus.bin_in[BIN_W-1];
    // -2^(BIN_W-1) negates to itself, which reads correctly as unsigned
    assign mag  = sign ? (~bus.bin_in + 1'b1) : bus.bin_in;
    assign bus.neg = neg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            if (bus.start && (state == IDLE || state == DONE))
                sign_q <= sign;
            if (state == SHIFT && cnt == '0)
                neg_q <= sign_q;
        end
    end
`else
    assign mag     = bus.bin_in;
    assign bus.neg = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            operand <= '0;
            scratch <= '0;
            cnt     <= '0;
            sticky  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd     <= '0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    // The edge leaving DONE doubles as the next accept slot
                    if (bus.start) begin
                        operand <= mag;
                        scratch <= '0;
                        sticky  <= 1'b0;
                        cnt     <= CNT_W'(BIN_W - 1);
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    scratch <= scratch_nxt;
                    operand <= {operand[BIN_W-2:0], 1'b0};
                    sticky  <= sticky | carry;
                    if (cnt == '0) begin
                        bcd   <= scratch_nxt;
                        ovf   <= sticky | carry;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.bcd_out  = bcd;
    assign bus.overflow = ovf;
endmodule

// File: tb/tb_seq_bin2bcd.sv
// Directed-vector bench for seq_bin2bcd: an 18-bit/6-digit instance
// and a 20-bit/6-digit instance sharing clock and reset.
module tb_seq_bin2bcd;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    seq_bin2bcd_if #(.BIN_W(18), .DIGITS(6)) a ();
    seq_bin2bcd_if #(.BIN_W(20), .DIGITS(6)) b ();

    seq_bin2bcd #(.BIN_W(18), .DIGITS(6)) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a)
    );

    seq_bin2bcd #(.BIN_W(20), .DIGITS(6)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_done_a(output int lat);
        lat = 0;
        while (!a.done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_a(input logic [17:0] v, output int lat);
        @(posedge clk); #1;
        a.start = 1'b1;
        a.bin_in = v;
        @(posedge clk); #1;
        a.start = 1'b0;
        check("busy_on_accept", 32'(a.busy), 32'd1);
        wait_done_a(lat);
    endtask

    task automatic run_b(input logic [19:0] v, output int lat);
        @(posedge clk); #1;
        b.start = 1'b1;
        b.bin_in = v;
        @(posedge clk); #1;
        b.start = 1'b0;
        lat = 0;
        while (!b.done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int ndone;
        a.start = 1'b0;
        a.bin_in = '0;
        b.start = 1'b0;
        b.bin_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(a.busy), 32'd0);
        check("rst_done", 32'(a.done), 32'd0);
        check("rst_bcd", 32'(a.bcd_out), 32'h0);
        check("rst_ovf", 32'(a.overflow), 32'd0);
        check("rst_neg", 32'(a.neg), 32'd0);
        rst_n = 1'b1;

        run_a(18'd0, lat);
        check("zero_lat", lat, 32'd18);
        check("zero_bcd", 32'(a.bcd_out), 32'h000000);
        check("zero_ovf", 32'(a.overflow), 32'd0);
        check("zero_neg", 32'(a.neg), 32'd0);
        @(posedge clk); #1;
        check("done_pulse", 32'(a.done), 32'd0);
        check("busy_fall", 32'(a.busy), 32'd0);
        check("hold_bcd", 32'(a.bcd_out), 32'h000000);

`ifndef SEQ_BIN2BCD_SIGNED_EN
        // Back-to-back: start held through the DONE cycle
        @(posedge clk); #1;
        a.start = 1'b1;
        a.bin_in = 18'd262143;
        @(posedge clk); #1;
        a.bin_in = 18'd99999;
        wait_done_a(lat);
        check("max_lat", lat, 32'd18);
        check("max_bcd", 32'(a.bcd_out), 32'h262143);
        check("max_ovf", 32'(a.overflow), 32'd0);
        check("max_neg", 32'(a.neg), 32'd0);
        @(posedge clk); #1;
        a.start = 1'b0;
        check("b2b_busy", 32'(a.busy), 32'd1);
        check("b2b_done_low", 32'(a.done), 32'd0);
        check("b2b_hold", 32'(a.bcd_out), 32'h262143);
        lat = 1;
        while (!a.done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b_period", lat, 32'd19);
        check("b2b_bcd", 32'(a.bcd_out), 32'h099999);

        run_b(20'd1048575, lat);
        check("w20_lat", lat, 32'd20);
        check("w20_ovf_bcd", 32'(b.bcd_out), 32'h048575);
        check("w20_ovf", 32'(b.overflow), 32'd1);
        run_b(20'd999999, lat);
        check("w20_bcd", 32'(b.bcd_out), 32'h999999);
        check("w20_no_ovf", 32'(b.overflow), 32'd0);
`else
        run_a(18'h3FFFF, lat);
        check("s_m1_bcd", 32'(a.bcd_out), 32'h000001);
        check("s_m1_neg", 32'(a.neg), 32'd1);
        run_a(18'h20000, lat);
        check("s_min_bcd", 32'(a.bcd_out), 32'h131072);
        check("s_min_neg", 32'(a.neg), 32'd1);
        check("s_min_ovf", 32'(a.overflow), 32'd0);
        run_a(18'h1FFFF, lat);
        check("s_max_bcd", 32'(a.bcd_out), 32'h131071);
        check("s_max_neg", 32'(a.neg), 32'd0);
        run_b(20'hFFFFE, lat);
        check("s_w20_bcd", 32'(b.bcd_out), 32'h000002);
        check("s_w20_neg", 32'(b.neg), 32'd1);
`endif

        // start re-pulsed mid-conversion is ignored
        @(posedge clk); #1;
        a.start = 1'b1;
        a.bin_in = 18'd12345;
        @(posedge clk); #1;
        a.bin_in = 18'd5;
        a.start = 1'b0;
        ndone = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i == 3 || i == 10) a.start = 1'b1;
            else a.start = 1'b0;
            @(posedge clk); #1;
            if (a.done) begin
                ndone++;
                check("ign_bcd", 32'(a.bcd_out), 32'h012345);
            end
        end
        check("ign_single_done", ndone, 32'd1);
        check("ign_idle", 32'(a.busy), 32'd0);

        // Asynchronous reset mid-SHIFT
        @(posedge clk); #1;
        a.start = 1'b1;
        a.bin_in = 18'd777;
        @(posedge clk); #1;
        a.start = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(a.busy), 32'd0);
        check("arst_bcd", 32'(a.bcd_out), 32'h0);
        check("arst_ovf", 32'(a.overflow), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (a.done) ndone++;
        end
        check("arst_no_done", ndone, 32'd0);
        check("arst_bcd_hold", 32'(a.bcd_out), 32'h0);
        run_a(18'd4321, lat);
        check("post_rst_lat", lat, 32'd18);
        check("post_rst_bcd", 32'(a.bcd_out), 32'h004321);
        check("post_rst_neg", 32'(a.neg), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
